unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the instruction-fetch port and the data (load/store) port.
//  Sits between the core pipeline and the memory; grant/valid outputs drive the pipeline controller's stage enables.
//  Data accesses have priority; a streak counter bounds fetch starvation. At most one read is in flight.
// PARAMETERS
//  ADDR_W           32  address width (byte address, word aligned)
//  DATA_W           32  data width
//  RD_LATENCY       1   memory read latency in cycles, legal 1..8
//  MAX_DATA_STREAK  4   consecutive data grants before a pending fetch is forced through, legal 1..15
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset (0 = reset asserted)
//  i_req      in   1       fetch request, held until i_gnt
//  i_addr     in   ADDR_W  fetch address
//  i_cancel   in   1       branch/exception redirect: drop the in-flight fetch response
//  i_gnt      out  1       fetch accepted this cycle
//  i_rvalid   out  1       fetch data valid (1-cycle pulse)
//  i_rdata    out  DATA_W  fetch data
//  d_req      in   1       data request, held until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data accepted this cycle
//  d_rvalid   out  1       load data valid (1-cycle pulse)
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid RD_LATENCY cycles after the mem_en read cycle
//  busy       out  1       read in flight
// BEHAVIOUR
//  - Reset (reset==0): state IDLE; streak=0; cnt=0; owner=NONE; every output 0.
//  - States: IDLE (no read in flight), WAIT (read outstanding, cnt counting down).
//  - Issue is legal in IDLE, or in WAIT on the cycle cnt==0 (back-to-back).
//    The mem_* outputs, i_gnt and d_gnt are combinational from the requests when issue is legal; otherwise all are 0.
//  - Pick order: d_req wins unless (i_req && streak==MAX_DATA_STREAK), in which case the fetch wins.
//  - Streak counter:
//    - data grant while i_req=1: streak++ (saturates at MAX_DATA_STREAK);
//    - fetch grant or i_req=0: streak=0.
//  - Store grant: mem_en=1, mem_we=1; completes in the same cycle with no response.
//    State is unchanged, or IDLE if the store is issued on the WAIT completion cycle.
//  - Read grant (fetch, or load): mem_en=1, mem_we=0; latch owner; cnt=RD_LATENCY-1; state goes to WAIT.
//  - WAIT with cnt!=0: cnt--, no issue.
//  - WAIT with cnt==0: mem_rdata is routed to the owner's rdata with a 1-cycle rvalid pulse.
//    Same cycle: a new issue may occur; if none, state goes to IDLE.
//  - Read latency seen by the requester = RD_LATENCY cycles after the grant cycle.
//  - Cancel: i_cancel while owner=FETCH in WAIT sets a drop flag; i_rvalid is suppressed on completion.
//    The memory slot is still consumed; the flag clears at completion.
//    i_cancel in the same cycle as an i_gnt drops that new fetch.
//  - i_rdata and d_rdata hold their last delivered value; they are 0 after reset.
//  - busy = (state==WAIT).
//  - Simultaneous requests with issue blocked: no grants; requesters hold; the streak is unchanged.
//  - Reset mid-read: the response is discarded, no rvalid after reset release.
//    The memory tolerates an abandoned read.
// STRUCTURE
//  - Shared package mem_arb_pkg: state enum (IDLE, WAIT), owner codes (NONE, FETCH, LOAD), RD_LATENCY/streak width constants.
//  - One sub-module mem_arb_pick: combinational priority and starvation pick.
//    Inputs i_req, d_req, streak, can_issue; outputs the grant vector.
//  - Top level holds the FSM, cnt, streak, owner, drop flag and the response mux.
// TESTING
//  1. Reset low mid-WAIT with RD_LATENCY=3 -> all outputs 0; no rvalid after reset release.
//  2. i_req only, i_addr=0x100, mem word 0x24020001, RD_LATENCY=1
//     -> i_gnt at cycle 0; i_rvalid=1, i_rdata=0x24020001 at cycle 1; back-to-back fetches every cycle.
//  3. i_req and d_req (loads) held, MAX_DATA_STREAK=4 -> grants D,D,D,D,I,D,D,D,D,I...; the fetch is never starved.
//  4. Store d_we=1, addr=0x40, wdata=0xDEADBEEF, then a load of 0x40
//     -> mem_we pulse in the store cycle; the load grant follows next cycle; d_rdata=0xDEADBEEF.
//  5. RD_LATENCY=3, fetch in flight, i_cancel at cycle 1 -> no i_rvalid at cycle 3; a pending d_req is granted at cycle 3.
//  6. Issue blocked during WAIT with both requests high
//     -> no i_gnt/d_gnt until the completion cycle; streak unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Imported by the pick logic and the arbiter top.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    LOAD
  } owner_t;

  // cnt holds RD_LATENCY-1 (max 7); streak holds up to 15
  localparam int CNT_W    = 3;
  localparam int STREAK_W = 4;

  // grant vector bit positions
  localparam int G_FETCH = 0;
  localparam int G_DATA  = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and data ports.
// Data wins unless a waiting fetch has seen a full data streak.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  input  logic                can_issue,
  output logic [1:0]          gnt
);

  logic starve;

  assign starve = i_req &&
    (streak == STREAK_W'(MAX_DATA_STREAK));

  // one-hot grant; nothing while issue is blocked
  always_comb begin
    gnt = '0;
    if (can_issue) begin
      if (i_req && (starve || !d_req))
        gnt[G_FETCH] = 1'b1;
      else if (d_req)
        gnt[G_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of a single-port fixed-latency memory.
// One read in flight; stores complete in their issue cycle.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t              state;
  owner_t              owner;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;
  logic                drop;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic       can_issue;
  logic       done;
  logic       read_gnt;
  logic [1:0] gnt;

  // reset gates issue so every output is 0 while held
  assign done = (state == WAIT) && (cnt == '0);
  assign can_issue = reset &&
    ((state == IDLE) || done);

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .streak   (streak),
    .can_issue(can_issue),
    .gnt      (gnt)
  );

  assign i_gnt    = gnt[G_FETCH];
  assign d_gnt    = gnt[G_DATA];
  assign read_gnt = i_gnt || (d_gnt && !d_we);

  // memory strobes follow the grant
  always_comb begin
    mem_en    = i_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt)
      mem_addr = i_addr;
    else if (d_gnt)
      mem_addr = d_addr;
    if (d_gnt && d_we)
      mem_wdata = d_wdata;
  end

  // completion routing; a same-cycle cancel also drops
  always_comb begin
    i_rvalid = done && (owner == FETCH) &&
      !drop && !i_cancel;
    d_rvalid = done && (owner == LOAD);
    i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
  end

  assign busy = (state == WAIT);

  // read FSM, latency counter, streak and held rdata
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= NONE;
      cnt       <= '0;
      streak    <= '0;
      drop      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rvalid)
        i_rdata_q <= mem_rdata;
      if (d_rvalid)
        d_rdata_q <= mem_rdata;

      if (i_gnt || !i_req)
        streak <= '0;
      else if (d_gnt &&
               streak != STREAK_W'(MAX_DATA_STREAK))
        streak <= streak + 1'b1;

      if (read_gnt) begin
        state <= WAIT;
        cnt   <= CNT_W'(RD_LATENCY - 1);
        owner <= i_gnt ? FETCH : LOAD;
        drop  <= i_gnt && i_cancel;
      end else if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (i_cancel && owner == FETCH)
            drop <= 1'b1;
        end else begin
          state <= IDLE;
          owner <= NONE;
          drop  <= 1'b0;
        end
      end
    end
  end

endmodule
